udma_hyper_cs_segmenter: RTL
============================

Name: udma_hyper_cs_segmenter

Overview:
- Sits directly downstream of the hyperbus config register block, between the uDMA channel transaction front-end and the hyperbus PHY controller.
- Consumes the cfg_t_cs_max and cfg_t_read_write_recovery register values.
- Splits each requested burst into CS-low segments so that no segment exceeds the tCSM budget.
- Enforces read/write recovery idle cycles between consecutive segments and transactions.

Parameters:
- TRANS_SIZE, 16, width of the transaction and segment length in 16-bit words.
- CMD_OVERHEAD, 8, fixed CS-low cycles per segment spent on CA phase and latency; subtracted from the tCSM budget.

Ports:
- clk_i  in  1  clock.
- rst_ni  in  1  asynchronous active-low reset.
- cfg_t_cs_max_i  in  32  max CS-low cycles, from register block.
- cfg_t_read_write_recovery_i  in  32  idle cycles required between CS-high and next CS-low.
- trans_valid_i  in  1  burst request valid.
- trans_ready_o  out  1  burst request accepted.
- trans_addr_i  in  32  burst start address, in bytes.
- trans_len_i  in  TRANS_SIZE  burst length in words.
- seg_valid_o  out  1  segment command valid to PHY controller.
- seg_ready_i  in  1  PHY controller accepts the segment.
- seg_addr_o  out  32  segment start address, in bytes.
- seg_len_o  out  TRANS_SIZE  segment length in words, always ≥1.
- seg_done_i  in  1  one-cycle pulse: PHY has raised CS for the current segment.
- trans_done_o  out  1  one-cycle pulse: whole burst finished, including final recovery.
- busy_o  out  1  high in every state except IDLE.

Behaviour:
- Reset values: trans_ready_o=1, seg_valid_o=0, seg_addr_o=0, seg_len_o=0, trans_done_o=0, busy_o=0, state=IDLE. All counters are cleared.
- Reset mid-operation aborts immediately. No done pulse is produced.
- trans_ready_o = (state==IDLE). A request is accepted on the cycle trans_valid_i && trans_ready_o.
- On accept, the block latches:
  - r_addr=trans_addr_i;
  - r_rem=trans_len_i;
  - r_rwr=cfg_t_read_write_recovery_i;
  - r_max = (cfg_t_cs_max_i > CMD_OVERHEAD) ? min(cfg_t_cs_max_i − CMD_OVERHEAD, 2^TRANS_SIZE−1) : 1.
- Config changes after accept have no effect until the next accept.
- FSM states and transitions:
  - IDLE: on accept with trans_len_i==0, go to DONE; on accept with any other length, go to ISSUE.
  - ISSUE:
    - seg_valid_o=1, seg_addr_o=r_addr, seg_len_o=min(r_rem, r_max). These outputs are registered and held stable until the handshake.
    - On seg_valid_o && seg_ready_i: r_rem −= seg_len; r_addr += 2*seg_len, wrapping modulo 2^32; go to WAIT_DONE.
  - WAIT_DONE: on seg_done_i, load recovery counter with r_rwr and go to RECOVER.
    - seg_done_i outside WAIT_DONE is ignored.
  - RECOVER: the counter decrements each cycle. When it reaches 0 (immediately if r_rwr==0):
    - r_rem!=0 → ISSUE;
    - r_rem==0 → DONE.
  - DONE: trans_done_o=1 for exactly one cycle, then go to IDLE.
- Timing:
  - Recovery of N gives exactly N cycles between the seg_done_i cycle and the next seg_valid_o rise, or the trans_done_o cycle.
  - With N=0, the next seg_valid_o asserts in the cycle after seg_done_i.
  - Zero-length burst: trans_done_o is asserted in the cycle after accept. No segment is issued.
- Arithmetic:
  - 32-bit unsigned compare for the r_max computation.
  - Segment count = ceil(len / r_max).
  - Address wrap-around past 0xFFFFFFFE is permitted and silent.

Decomposition:
- Shared hyperbus package holds:
  - the FSM state enum (IDLE, ISSUE, WAIT_DONE, RECOVER, DONE);
  - CMD_OVERHEAD default as a localparam constant.
- One sub-module: udma_hyper_down_counter, a loadable 32-bit down counter with a zero flag, used for recovery.

Test Plan:
- cs_max=665, rwr=6, len=100 at addr 0x1000 → one segment (0x1000, 100); trans_done_o 7 cycles after seg_done_i.
- cs_max=58 (r_max=50), rwr=2, len=120, addr 0x0 → segments (0x0,50), (0x64,50), (0xC8,20); exactly 2 idle cycles after each seg_done_i.
- cs_max=5 (≤ CMD_OVERHEAD), len=3 → three 1-word segments at addr, addr+2, addr+4.
- len=0 → no seg_valid_o; trans_done_o in the cycle after accept; trans_ready_o returns to 1 the following cycle.
- seg_ready_i held low 10 cycles → seg_valid_o, seg_addr_o and seg_len_o stay constant throughout. Changing cfg_t_cs_max_i mid-burst → segment lengths are unchanged.
- Async reset asserted in RECOVER → all outputs at reset values immediately; a new request after reset is accepted normally.

Source files
------------

// File: rtl/udma_hyper_cs_segmenter_pkg.sv
// Shared hyperbus definitions for the CS segmenter: FSM state encoding,
// default command overhead and a small unsigned min helper.
package udma_hyper_cs_segmenter_pkg;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_ISSUE     = 3'd1,
        ST_WAIT_DONE = 3'd2,
        ST_RECOVER   = 3'd3,
        ST_DONE      = 3'd4
    } seg_state_e;

    localparam int unsigned CMD_OVERHEAD_DEFAULT = 8;

    function automatic logic [31:0] min_u32(input logic [31:0] a, input logic [31:0] b);
        return (a < b) ? a : b;
    endfunction

endpackage

// File: rtl/udma_hyper_down_counter.sv
// Loadable 32-bit down counter that saturates at zero and flags it.
module udma_hyper_down_counter (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        i_load,
    input  logic [31:0] i_load_val,
    input  logic        i_dec,
    output logic        o_zero
);

    logic [31:0] r_count;

    // Count register: load has priority over decrement.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_count <= 32'd0;
        end else if (i_load) begin
            r_count <= i_load_val;
        end else if (i_dec && (r_count != 32'd0)) begin
            r_count <= r_count - 32'd1;
        end else begin
            r_count <= r_count;
        end
    end

    assign o_zero = (r_count == 32'd0);

endmodule

// File: rtl/udma_hyper_cs_segmenter.sv
// Splits uDMA hyperbus bursts into CS-low segments bounded by tCSM and
// inserts read/write recovery idle time between segments and bursts.
module udma_hyper_cs_segmenter
    import udma_hyper_cs_segmenter_pkg::*;
#(
    parameter int unsigned TRANS_SIZE   = 16,
    parameter int unsigned CMD_OVERHEAD = CMD_OVERHEAD_DEFAULT
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic [31:0]           cfg_t_cs_max_i,
    input  logic [31:0]           cfg_t_read_write_recovery_i,
    input  logic                  trans_valid_i,
    output logic                  trans_ready_o,
    input  logic [31:0]           trans_addr_i,
    input  logic [TRANS_SIZE-1:0] trans_len_i,
    output logic                  seg_valid_o,
    input  logic                  seg_ready_i,
    output logic [31:0]           seg_addr_o,
    output logic [TRANS_SIZE-1:0] seg_len_o,
    input  logic                  seg_done_i,
    output logic                  trans_done_o,
    output logic                  busy_o
);

    localparam logic [31:0] MAX_LEN = 32'((64'd1 << TRANS_SIZE) - 64'd1);
    localparam logic [31:0] OVH     = 32'(CMD_OVERHEAD);

    seg_state_e            r_state;
    logic [31:0]           r_addr;
    logic [TRANS_SIZE-1:0] r_rem;
    logic [31:0]           r_rwr;
    logic [TRANS_SIZE-1:0] r_max;
    logic                  r_ready;
    logic                  r_busy;
    logic                  r_seg_valid;
    logic [31:0]           r_seg_addr;
    logic [TRANS_SIZE-1:0] r_seg_len;
    logic                  r_trans_done;

    logic [TRANS_SIZE-1:0] w_max_new;
    logic [TRANS_SIZE-1:0] w_first_len;
    logic [TRANS_SIZE-1:0] w_next_len;
    logic [31:0]           w_addr_step;
    logic                  w_cnt_load;
    logic                  w_cnt_dec;
    logic                  w_cnt_zero;

    // Per-segment word budget from the live config, and segment sizing.
    always_comb begin
        w_max_new   = TRANS_SIZE'(1);
        w_first_len = '0;
        w_next_len  = '0;
        w_addr_step = 32'd0;
        if (cfg_t_cs_max_i > OVH) begin
            w_max_new = TRANS_SIZE'(min_u32(cfg_t_cs_max_i - OVH, MAX_LEN));
        end else begin
            w_max_new = TRANS_SIZE'(1);
        end
        w_first_len = TRANS_SIZE'(min_u32(32'(trans_len_i), 32'(w_max_new)));
        w_next_len  = TRANS_SIZE'(min_u32(32'(r_rem), 32'(r_max)));
        w_addr_step = 32'(r_seg_len) << 1;
    end

    // Counter holds rwr-1 so its zero flag marks the last recovery cycle;
    // rwr==0 bypasses RECOVER entirely.
    assign w_cnt_load = (r_state == ST_WAIT_DONE) && seg_done_i && (r_rwr != 32'd0);
    assign w_cnt_dec  = (r_state == ST_RECOVER);

    udma_hyper_down_counter u_rwr_cnt (
        .clk_i      (clk_i),
        .rst_ni     (rst_ni),
        .i_load     (w_cnt_load),
        .i_load_val (r_rwr - 32'd1),
        .i_dec      (w_cnt_dec),
        .o_zero     (w_cnt_zero)
    );

    // Segmenting FSM with registered handshake and status outputs.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state      <= ST_IDLE;
            r_addr       <= 32'd0;
            r_rem        <= '0;
            r_rwr        <= 32'd0;
            r_max        <= '0;
            r_ready      <= 1'b1;
            r_busy       <= 1'b0;
            r_seg_valid  <= 1'b0;
            r_seg_addr   <= 32'd0;
            r_seg_len    <= '0;
            r_trans_done <= 1'b0;
        end else begin
            r_trans_done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (trans_valid_i) begin
                        r_addr  <= trans_addr_i;
                        r_rem   <= trans_len_i;
                        r_rwr   <= cfg_t_read_write_recovery_i;
                        r_max   <= w_max_new;
                        r_ready <= 1'b0;
                        r_busy  <= 1'b1;
                        if (trans_len_i == '0) begin
                            r_state      <= ST_DONE;
                            r_trans_done <= 1'b1;
                        end else begin
                            r_state     <= ST_ISSUE;
                            r_seg_valid <= 1'b1;
                            r_seg_addr  <= trans_addr_i;
                            r_seg_len   <= w_first_len;
                        end
                    end
                end
                ST_ISSUE: begin
                    if (seg_ready_i) begin
                        r_rem       <= r_rem - r_seg_len;
                        r_addr      <= r_addr + w_addr_step;
                        r_seg_valid <= 1'b0;
                        r_state     <= ST_WAIT_DONE;
                    end
                end
                ST_WAIT_DONE: begin
                    if (seg_done_i) begin
                        if (r_rwr != 32'd0) begin
                            r_state <= ST_RECOVER;
                        end else if (r_rem != '0) begin
                            r_state     <= ST_ISSUE;
                            r_seg_valid <= 1'b1;
                            r_seg_addr  <= r_addr;
                            r_seg_len   <= w_next_len;
                        end else begin
                            r_state      <= ST_DONE;
                            r_trans_done <= 1'b1;
                        end
                    end
                end
                ST_RECOVER: begin
                    if (w_cnt_zero) begin
                        if (r_rem != '0) begin
                            r_state     <= ST_ISSUE;
                            r_seg_valid <= 1'b1;
                            r_seg_addr  <= r_addr;
                            r_seg_len   <= w_next_len;
                        end else begin
                            r_state      <= ST_DONE;
                            r_trans_done <= 1'b1;
                        end
                    end
                end
                ST_DONE: begin
                    r_state <= ST_IDLE;
                    r_ready <= 1'b1;
                    r_busy  <= 1'b0;
                end
                default: begin
                    r_state     <= ST_IDLE;
                    r_ready     <= 1'b1;
                    r_busy      <= 1'b0;
                    r_seg_valid <= 1'b0;
                end
            endcase
        end
    end

    assign trans_ready_o = r_ready;
    assign busy_o        = r_busy;
    assign seg_valid_o   = r_seg_valid;
    assign seg_addr_o    = r_seg_addr;
    assign seg_len_o     = r_seg_len;
    assign trans_done_o  = r_trans_done;

endmodule
